// File: rtl/s1_arduino_tx.sv
// s1_arduino_tx: one-byte UART transmitter toward the Arduino sound module.
// Sends {3'b101, sel_memoria, nota} whenever the selected note changes while
// the link is active. Define S1_ARDUINO_TX_PARITY_EN for 8E1 frames
// (default build sends 8N1).
module s1_arduino_tx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       activate,
   input  logic       sel_memoria,
   input  logic [3:0] nota_memoria,
   input  logic [3:0] nota_botoes,
   output logic       tx,
   output logic       ocupado,
   output logic [2:0] db_estado
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] OCIOSO   = 3'd0;
   localparam logic [2:0] INICIO   = 3'd1;
   localparam logic [2:0] DADOS    = 3'd2;
`ifdef S1_ARDUINO_TX_PARITY_EN
   localparam logic [2:0] PARIDADE = 3'd3;
`endif
   localparam logic [2:0] FIM      = 3'd4;

   logic [2:0]        state;
   logic [7:0]        payload;
   logic [7:0]        ultimo;
   logic              valido;
   logic              pendente;
   logic [7:0]        shift;
   logic [3:0]        bitCnt;
   logic [BAUD_W-1:0] baudCnt;
   logic              bitEnd;
`ifdef S1_ARDUINO_TX_PARITY_EN
   logic              parityBit;
`endif

   assign payload   = {3'b101, sel_memoria, (sel_memoria ? nota_memoria : nota_botoes)};
   assign bitEnd    = (baudCnt == BAUD_LAST);
   assign ocupado   = (state != OCIOSO);
   assign db_estado = state;

   // Change detection: one-deep queue holding the newest payload.
   // A new change takes priority over the idle-state consume so it is never lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ultimo   <= '0;
         valido   <= 1'b0;
         pendente <= 1'b0;
      end else if (!activate) begin
         valido   <= 1'b0;
         pendente <= 1'b0;
      end else if (!valido || (payload != ultimo)) begin
         ultimo   <= payload;
         valido   <= 1'b1;
         pendente <= 1'b1;
      end else if (state == OCIOSO) begin
         pendente <= 1'b0;
      end
   end

   // Frame sequencer: start, 8 data bits LSB first, optional parity, stop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= OCIOSO;
         shift     <= '0;
         bitCnt    <= '0;
         baudCnt   <= '0;
`ifdef S1_ARDUINO_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         case (state)
            OCIOSO: begin
               baudCnt <= '0;
               bitCnt  <= '0;
               if (pendente) begin
                  shift     <= ultimo;
`ifdef S1_ARDUINO_TX_PARITY_EN
                  parityBit <= ^ultimo;
`endif
                  state     <= INICIO;
               end
            end
            INICIO: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  state   <= DADOS;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DADOS: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  shift   <= {1'b0, shift[7:1]};
                  if (bitCnt == 4'd7) begin
                     bitCnt <= '0;
`ifdef S1_ARDUINO_TX_PARITY_EN
                     state  <= PARIDADE;
`else
                     state  <= FIM;
`endif
                  end else begin
                     bitCnt <= bitCnt + 1'b1;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
`ifdef S1_ARDUINO_TX_PARITY_EN
            PARIDADE: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  state   <= FIM;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
`endif
            FIM: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  state   <= OCIOSO;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: begin
               baudCnt <= '0;
               bitCnt  <= '0;
               state   <= OCIOSO;
            end
         endcase
      end
   end

   // Line level decoded from the current state; idle, stop and illegal states drive high.
   always_comb begin
      tx = 1'b1;
      case (state)
         INICIO:   tx = 1'b0;
         DADOS:    tx = shift[0];
`ifdef S1_ARDUINO_TX_PARITY_EN
         PARIDADE: tx = parityBit;
`endif
         default:  tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_s1_arduino_tx.sv
// Directed bench for s1_arduino_tx at 16 clocks per bit.
module tb_s1_arduino_tx;

   localparam int CPB = 16;
`ifdef S1_ARDUINO_TX_PARITY_EN
   localparam int FRAME_LEN = 176;
   localparam int STOP_IDX  = 10;
`else
   localparam int FRAME_LEN = 160;
   localparam int STOP_IDX  = 9;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       activate = 1'b0;
   logic       sel_memoria = 1'b0;
   logic [3:0] nota_memoria = 4'd0;
   logic [3:0] nota_botoes = 4'd0;
   logic       tx;
   logic       ocupado;
   logic [2:0] db_estado;

   int assertCount = 0;
   int failCount = 0;

   // Results of the most recent rx_frame call.
   logic        rxFound;
   int          rxWait;
   logic [10:0] rxBits;
   logic [2:0]  rxStStart;
   logic [2:0]  rxStData;
   int          rxBusy;

   s1_arduino_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
      .clock(clock),
      .reset(reset),
      .activate(activate),
      .sel_memoria(sel_memoria),
      .nota_memoria(nota_memoria),
      .nota_botoes(nota_botoes),
      .tx(tx),
      .ocupado(ocupado),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Waits (bounded) for a start bit, then samples every bit mid-period
   // and measures how long ocupado stays high.
   task automatic rx_frame(input int maxWait);
      int k;
      rxFound = 1'b0; rxWait = 0; rxBits = '1; rxStStart = 3'd7; rxStData = 3'd7; rxBusy = 0;
      while (!rxFound && rxWait < maxWait) begin
         @(posedge clock); #1;
         rxWait++;
         if (tx === 1'b0) rxFound = 1'b1;
      end
      if (rxFound) begin
         rxStStart = db_estado;
         k = 0;
         while (ocupado === 1'b1 && k < 400) begin
            if ((k % CPB) == CPB/2 && (k / CPB) <= 10) rxBits[k / CPB] = tx;
            if (k == CPB + CPB/2) rxStData = db_estado;
            rxBusy++;
            k++;
            @(posedge clock); #1;
         end
      end
   endtask

   // Counts cycles with ocupado or a low line over a window.
   task automatic idle_window(input int cycles, output int busySeen);
      busySeen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock); #1;
         if (ocupado !== 1'b0 || tx !== 1'b1) busySeen++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      assertCount++;
      if (tx !== 1'b1) begin failCount++; $display("FAIL reset_tx: got %b expected 1", tx); end
      assertCount++;
      if (ocupado !== 1'b0) begin failCount++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
      assertCount++;
      if (db_estado !== 3'd0) begin failCount++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
      reset = 1'b1;
   endtask

   task automatic test_inactive;
      for (int i = 0; i < 48; i++) begin
         nota_memoria = 4'(i);
         nota_botoes  = ~4'(i);
         sel_memoria  = i[0];
         @(posedge clock); #1;
         assertCount++;
         if (tx !== 1'b1 || ocupado !== 1'b0) begin
            failCount++;
            $display("FAIL inactive_idle: cycle %0d got tx=%b ocupado=%b expected tx=1 ocupado=0", i, tx, ocupado);
         end
      end
   endtask

   // First frame B4; meanwhile the button note moves to 1 then 2.
   task automatic test_first_frame;
      sel_memoria = 1'b1; nota_memoria = 4'b0100; nota_botoes = 4'd0;
      @(posedge clock); #1;
      activate = 1'b1;
      fork
         rx_frame(10);
         begin
            repeat (30) @(posedge clock);
            #2; sel_memoria = 1'b0; nota_botoes = 4'd1;
            repeat (30) @(posedge clock);
            #2; nota_botoes = 4'd2;
         end
      join
      assertCount++;
      if (rxFound !== 1'b1) begin failCount++; $display("FAIL first_found: got %b expected 1", rxFound); end
      assertCount++;
      if (rxWait != 2) begin failCount++; $display("FAIL first_latency: got %0d expected 2", rxWait); end
      assertCount++;
      if (rxStStart !== 3'd1) begin failCount++; $display("FAIL first_estado_inicio: got %0d expected 1", rxStStart); end
      assertCount++;
      if (rxStData !== 3'd2) begin failCount++; $display("FAIL first_estado_dados: got %0d expected 2", rxStData); end
      assertCount++;
      if (rxBits[0] !== 1'b0) begin failCount++; $display("FAIL first_start: got %b expected 0", rxBits[0]); end
      assertCount++;
      if (rxBits[8:1] !== 8'hB4) begin failCount++; $display("FAIL first_data: got %h expected b4", rxBits[8:1]); end
`ifdef S1_ARDUINO_TX_PARITY_EN
      assertCount++;
      if (rxBits[9] !== 1'b0) begin failCount++; $display("FAIL first_parity: got %b expected 0", rxBits[9]); end
`endif
      assertCount++;
      if (rxBits[STOP_IDX] !== 1'b1) begin failCount++; $display("FAIL first_stop: got %b expected 1", rxBits[STOP_IDX]); end
      assertCount++;
      if (rxBusy != FRAME_LEN) begin failCount++; $display("FAIL first_busy_len: got %0d expected %0d", rxBusy, FRAME_LEN); end
   endtask

   // Only the newest queued value (A2) follows, one idle cycle later.
   task automatic test_back_to_back;
      int busySeen;
      rx_frame(4);
      assertCount++;
      if (rxFound !== 1'b1) begin failCount++; $display("FAIL b2b_found: got %b expected 1", rxFound); end
      assertCount++;
      if (rxWait != 1) begin failCount++; $display("FAIL b2b_gap: got %0d expected 1", rxWait); end
      assertCount++;
      if (rxBits[8:1] !== 8'hA2) begin failCount++; $display("FAIL b2b_data: got %h expected a2", rxBits[8:1]); end
`ifdef S1_ARDUINO_TX_PARITY_EN
      assertCount++;
      if (rxBits[9] !== 1'b1) begin failCount++; $display("FAIL b2b_parity: got %b expected 1", rxBits[9]); end
`endif
      assertCount++;
      if (rxBits[STOP_IDX] !== 1'b1) begin failCount++; $display("FAIL b2b_stop: got %b expected 1", rxBits[STOP_IDX]); end
      assertCount++;
      if (rxBusy != FRAME_LEN) begin failCount++; $display("FAIL b2b_busy_len: got %0d expected %0d", rxBusy, FRAME_LEN); end
      idle_window(250, busySeen);
      assertCount++;
      if (busySeen != 0) begin failCount++; $display("FAIL b2b_no_third: got %0d busy cycles expected 0", busySeen); end
   endtask

   task automatic test_activate_drop;
      int busySeen;
      nota_botoes = 4'd3;
      fork
         rx_frame(10);
         begin
            repeat (42) @(posedge clock);
            #2; activate = 1'b0;
         end
      join
      assertCount++;
      if (rxWait != 2) begin failCount++; $display("FAIL drop_latency: got %0d expected 2", rxWait); end
      assertCount++;
      if (rxBits[8:1] !== 8'hA3) begin failCount++; $display("FAIL drop_data: got %h expected a3", rxBits[8:1]); end
      assertCount++;
      if (rxBits[STOP_IDX] !== 1'b1) begin failCount++; $display("FAIL drop_stop: got %b expected 1", rxBits[STOP_IDX]); end
      assertCount++;
      if (rxBusy != FRAME_LEN) begin failCount++; $display("FAIL drop_busy_len: got %0d expected %0d", rxBusy, FRAME_LEN); end
      idle_window(100, busySeen);
      assertCount++;
      if (busySeen != 0) begin failCount++; $display("FAIL drop_no_followup: got %0d busy cycles expected 0", busySeen); end
      activate = 1'b1;
      rx_frame(10);
      assertCount++;
      if (rxWait != 2) begin failCount++; $display("FAIL reactivate_latency: got %0d expected 2", rxWait); end
      assertCount++;
      if (rxBits[8:1] !== 8'hA3) begin failCount++; $display("FAIL reactivate_data: got %h expected a3", rxBits[8:1]); end
   endtask

   task automatic test_reset_midframe;
      int waited;
      int busySeen;
      nota_botoes = 4'd5;
      waited = 0;
      while (tx !== 1'b0 && waited < 10) begin
         @(posedge clock); #1;
         waited++;
      end
      assertCount++;
      if (tx !== 1'b0) begin failCount++; $display("FAIL rstmid_start: got %b expected 0", tx); end
      repeat (72) @(posedge clock);
      #1;
      assertCount++;
      if (tx !== 1'b0) begin failCount++; $display("FAIL rstmid_bit3: got %b expected 0", tx); end
      #2; reset = 1'b0;
      #1;
      assertCount++;
      if (tx !== 1'b1) begin failCount++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
      assertCount++;
      if (ocupado !== 1'b0) begin failCount++; $display("FAIL rstmid_ocupado: got %b expected 0", ocupado); end
      assertCount++;
      if (db_estado !== 3'd0) begin failCount++; $display("FAIL rstmid_estado: got %0d expected 0", db_estado); end
      activate = 1'b0;
      repeat (3) @(posedge clock);
      #1; reset = 1'b1;
      idle_window(100, busySeen);
      assertCount++;
      if (busySeen != 0) begin failCount++; $display("FAIL rstmid_no_frame: got %0d busy cycles expected 0", busySeen); end
      activate = 1'b1;
      rx_frame(10);
      assertCount++;
      if (rxWait != 2) begin failCount++; $display("FAIL rstmid_retrigger_latency: got %0d expected 2", rxWait); end
      assertCount++;
      if (rxBits[8:1] !== 8'hA5) begin failCount++; $display("FAIL rstmid_retrigger_data: got %h expected a5", rxBits[8:1]); end
   endtask

   // Memory source with note 1: payload B1 has four ones, even parity bit 0.
   task automatic test_memory_source;
      sel_memoria = 1'b1; nota_memoria = 4'b0001;
      rx_frame(10);
      assertCount++;
      if (rxWait != 2) begin failCount++; $display("FAIL mem_latency: got %0d expected 2", rxWait); end
      assertCount++;
      if (rxBits[8:1] !== 8'hB1) begin failCount++; $display("FAIL mem_data: got %h expected b1", rxBits[8:1]); end
`ifdef S1_ARDUINO_TX_PARITY_EN
      assertCount++;
      if (rxBits[9] !== 1'b0) begin failCount++; $display("FAIL mem_parity: got %b expected 0", rxBits[9]); end
`endif
      assertCount++;
      if (rxBits[STOP_IDX] !== 1'b1) begin failCount++; $display("FAIL mem_stop: got %b expected 1", rxBits[STOP_IDX]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_inactive();
      test_first_frame();
      test_back_to_back();
      test_activate_drop();
      test_reset_midframe();
      test_memory_source();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
